// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter in front of a word-wide data memory.
// Turns byte-addressed byte/half/word accesses into word cycles. Sub-word
// stores use read-modify-write. Loads are lane-extracted and extended.
// Optional build macro: ARB_RR_EN selects round-robin arbitration instead of
// fixed priority (P0_PRIO).
module data_mem_arbiter #(
   parameter int unsigned IDX_W   = 12,
   parameter bit          P0_PRIO = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p0_valid,
   input  logic        p0_write,
   input  logic [1:0]  p0_size,
   input  logic        p0_unsigned,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_done,
   output logic        p0_err,
   output logic [31:0] p0_rdata,
   input  logic        p1_valid,
   input  logic        p1_write,
   input  logic [1:0]  p1_size,
   input  logic        p1_unsigned,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_done,
   output logic        p1_err,
   output logic [31:0] p1_rdata,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable,
   input  logic [31:0] mem_read_data
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RMW_WR} state_t;

   state_t            state_q, state_d;
   logic              grant_q, grant_d;
   logic              write_q, write_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [1:0]        off_q, off_d;
   logic              bad_q, bad_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wd_q, wd_d;
   logic              we_q, we_d;
   logic [1:0]        done_q, done_d;
   logic [1:0]        err_q, err_d;
   logic [1:0][31:0]  rdata_q, rdata_d;
`ifdef ARB_RR_EN
   logic              rr_q, rr_d;
`endif

   logic              sel;
   logic              s_write, s_uns, s_bad;
   logic [1:0]        s_size;
   logic [31:0]       s_addr, s_wdata;
   logic [31:0]       shifted, load_ext, rd_now, merged;
   logic              acc_load;
   logic              unused_ok;

   // Address bits above the word index never reach the memory.
   assign unused_ok = ^{p0_addr[31:IDX_W+2], p1_addr[31:IDX_W+2], P0_PRIO};

   // Grant selection among pending requests.
   always_comb begin
      sel = p1_valid;
`ifdef ARB_RR_EN
      if (p0_valid && p1_valid) sel = rr_q;
`else
      if (p0_valid && p1_valid) sel = ~P0_PRIO;
`endif
   end

   // Field mux of the granted port plus alignment/size check.
   always_comb begin
      s_write = sel ? p1_write    : p0_write;
      s_size  = sel ? p1_size     : p0_size;
      s_uns   = sel ? p1_unsigned : p0_unsigned;
      s_addr  = sel ? p1_addr     : p0_addr;
      s_wdata = sel ? p1_wdata    : p0_wdata;
      s_bad   = (s_size == 2'b11) ||
                ((s_size == SZ_HALF) && s_addr[0]) ||
                ((s_size == SZ_WORD) && (s_addr[1:0] != 2'b00));
   end

   // Load lane extraction/extension and store lane merge.
   always_comb begin
      shifted = mem_read_data >> {off_q, 3'b000};
      case (size_q)
         SZ_BYTE: load_ext = uns_q ? {24'b0, shifted[7:0]}   : {{24{shifted[7]}}, shifted[7:0]};
         SZ_HALF: load_ext = uns_q ? {16'b0, shifted[15:0]}  : {{16{shifted[15]}}, shifted[15:0]};
         default: load_ext = shifted;
      endcase
      rd_now = bad_q ? 32'b0 : load_ext;
      merged = mem_read_data;
      if (size_q == SZ_BYTE) merged[{off_q, 3'b000} +: 8]  = wdata_q[7:0];
      else                   merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   // Load data is presented during ACCESS while the memory read is live.
   assign acc_load = (state_q == S_ACCESS) && !write_q;
   assign p0_rdata = (acc_load && !grant_q) ? rd_now : rdata_q[0];
   assign p1_rdata = (acc_load &&  grant_q) ? rd_now : rdata_q[1];

   assign p0_done          = done_q[0];
   assign p1_done          = done_q[1];
   assign p0_err           = err_q[0];
   assign p1_err           = err_q[1];
   assign mem_address      = addr_q;
   assign mem_write_data   = wd_q;
   assign mem_write_enable = we_q;

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      write_d = write_q;
      size_d  = size_q;
      uns_d   = uns_q;
      off_d   = off_q;
      bad_d   = bad_q;
      wdata_d = wdata_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      we_d    = 1'b0;
      done_d  = 2'b00;
      err_d   = 2'b00;
      rdata_d = rdata_q;
`ifdef ARB_RR_EN
      rr_d    = rr_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (p0_valid || p1_valid) begin
               grant_d = sel;
               write_d = s_write;
               size_d  = s_size;
               uns_d   = s_uns;
               off_d   = s_addr[1:0];
               bad_d   = s_bad;
               wdata_d = s_wdata;
               addr_d  = 32'(s_addr[IDX_W+1:2]);
               // Loads, errors and word stores all finish in ACCESS.
               if (!s_bad && s_write && (s_size == SZ_WORD)) begin
                  wd_d = s_wdata;
                  we_d = 1'b1;
               end
               done_d[sel] = s_bad || !s_write || (s_size == SZ_WORD);
               err_d[sel]  = s_bad;
`ifdef ARB_RR_EN
               rr_d = ~sel;
`endif
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (acc_load) rdata_d[grant_q] = rd_now;
            if (bad_q || !write_q || (size_q == SZ_WORD)) begin
               state_d = S_IDLE;
            end else begin
               wd_d            = merged;
               we_d            = 1'b1;
               done_d[grant_q] = 1'b1;
               state_d         = S_RMW_WR;
            end
         end
         S_RMW_WR: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         grant_q <= 1'b0;
         write_q <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         off_q   <= 2'b00;
         bad_q   <= 1'b0;
         wdata_q <= 32'b0;
         addr_q  <= 32'b0;
         wd_q    <= 32'b0;
         we_q    <= 1'b0;
         done_q  <= 2'b00;
         err_q   <= 2'b00;
         rdata_q <= '0;
`ifdef ARB_RR_EN
         rr_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         write_q <= write_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         off_q   <= off_d;
         bad_q   <= bad_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         we_q    <= we_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
`ifdef ARB_RR_EN
         rr_q    <= rr_d;
`endif
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed bench for data_mem_arbiter with a 16-word
// memory model (combinational read, write on the rising edge).
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0_valid, p0_write, p0_unsigned;
   logic [1:0]  p0_size;
   logic [31:0] p0_addr, p0_wdata;
   logic        p0_done, p0_err;
   logic [31:0] p0_rdata;
   logic        p1_valid, p1_write, p1_unsigned;
   logic [1:0]  p1_size;
   logic [31:0] p1_addr, p1_wdata;
   logic        p1_done, p1_err;
   logic [31:0] p1_rdata;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
   logic        mem_write_enable;

   logic [31:0] mem [16];
   logic        mem_init;
   int          we_count;
   int          checks = 0;
   int          failures = 0;
   logic        unused_tb;

   always #5 clk = ~clk;

   data_mem_arbiter #(.IDX_W(12), .P0_PRIO(1'b1)) dut (
      .clk(clk), .reset(reset),
      .p0_valid(p0_valid), .p0_write(p0_write), .p0_size(p0_size),
      .p0_unsigned(p0_unsigned), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
      .p1_valid(p1_valid), .p1_write(p1_write), .p1_size(p1_size),
      .p1_unsigned(p1_unsigned), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
   );

   assign mem_read_data = mem[mem_address[3:0]];
   assign unused_tb     = ^mem_address[31:4];

   // Memory model: synchronous write, write-strobe counter.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'b0;
         we_count <= 0;
      end else if (mem_write_enable) begin
         mem[mem_address[3:0]] <= mem_write_data;
         we_count <= we_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Issue one port-0 request from a falling edge; returns at the done edge.
   task automatic p0_access(input logic wr, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int lat, output logic e, output logic [31:0] rd);
      p0_write = wr; p0_size = sz; p0_unsigned = uns; p0_addr = a; p0_wdata = wd;
      p0_valid = 1'b1;
      lat = 0; e = 1'b0; rd = 32'b0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); @(negedge clk);
         if (p0_done) begin
            lat = i; e = p0_err; rd = p0_rdata;
            break;
         end
      end
      p0_valid = 1'b0;
   endtask

   int          lat;
   logic        e;
   logic [31:0] rd;
   int          wc;
   logic [31:0] m1;
   logic        seen;
   int          seq [4];
   int          n;

   initial begin
      reset = 1'b1; mem_init = 1'b1;
      p0_valid = 0; p0_write = 0; p0_size = 0; p0_unsigned = 0; p0_addr = 0; p0_wdata = 0;
      p1_valid = 0; p1_write = 0; p1_size = 0; p1_unsigned = 0; p1_addr = 0; p1_wdata = 0;
      repeat (2) @(negedge clk);
      check("rst_p0_done", 32'(p0_done), 32'd0);
      check("rst_p1_done", 32'(p1_done), 32'd0);
      check("rst_we", 32'(mem_write_enable), 32'd0);
      check("rst_addr", mem_address, 32'd0);
      check("rst_wdata", mem_write_data, 32'd0);
      check("rst_p0_rdata", p0_rdata, 32'd0);
      reset = 1'b0; mem_init = 1'b0;
      @(negedge clk);

      // Word store then load.
      p0_access(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, lat, e, rd);
      check("wst_lat", 32'(lat), 32'd1);
      check("wst_err", 32'(e), 32'd0);
      check("wst_we", 32'(mem_write_enable), 32'd1);
      check("wst_addr", mem_address, 32'd2);
      @(negedge clk);
      check("wst_we_off", 32'(mem_write_enable), 32'd0);
      check("wst_mem", mem[2], 32'hDEADBEEF);
      check("wst_we_cnt", 32'(we_count), 32'd1);
      p0_access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, e, rd);
      check("wld_lat", 32'(lat), 32'd1);
      check("wld_data", rd, 32'hDEADBEEF);
      @(negedge clk);

      // Byte read-modify-write and byte loads.
      p0_access(1'b1, 2'b10, 1'b0, 32'h4, 32'h11223344, lat, e, rd);
      @(negedge clk);
      p0_access(1'b1, 2'b00, 1'b0, 32'h6, 32'h555555AA, lat, e, rd);
      check("bst_lat", 32'(lat), 32'd2);
      check("bst_addr", mem_address, 32'd1);
      check("bst_wdata", mem_write_data, 32'h11AA3344);
      @(negedge clk);
      check("bst_mem", mem[1], 32'h11AA3344);
      p0_access(1'b0, 2'b00, 1'b0, 32'h6, 32'h0, lat, e, rd);
      check("bld_signed", rd, 32'hFFFFFFAA);
      @(negedge clk);
      p0_access(1'b0, 2'b00, 1'b1, 32'h6, 32'h0, lat, e, rd);
      check("bld_unsigned", rd, 32'h000000AA);
      @(negedge clk);

      // Half read-modify-write into the upper lane, half/byte loads.
      p0_access(1'b1, 2'b01, 1'b0, 32'hA, 32'hFFFF1234, lat, e, rd);
      check("hst_lat", 32'(lat), 32'd2);
      @(negedge clk);
      check("hst_mem", mem[2], 32'h1234BEEF);
      p0_access(1'b0, 2'b01, 1'b0, 32'h8, 32'h0, lat, e, rd);
      check("hld_lo_signed", rd, 32'hFFFFBEEF);
      @(negedge clk);
      p0_access(1'b0, 2'b01, 1'b0, 32'hA, 32'h0, lat, e, rd);
      check("hld_hi_signed", rd, 32'h00001234);
      @(negedge clk);
      p0_access(1'b0, 2'b00, 1'b1, 32'hB, 32'h0, lat, e, rd);
      check("bld_lane3", rd, 32'h00000012);
      @(negedge clk);

      // Misaligned and illegal-size accesses.
      wc = we_count;
      p0_access(1'b1, 2'b01, 1'b0, 32'h3, 32'h00005555, lat, e, rd);
      check("mis_half_err", 32'(e), 32'd1);
      check("mis_half_lat", 32'(lat), 32'd1);
      @(negedge clk);
      p0_access(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, lat, e, rd);
      check("mis_word_err", 32'(e), 32'd1);
      @(negedge clk);
      p0_access(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, lat, e, rd);
      check("sz11_err", 32'(e), 32'd1);
      check("sz11_rdata", rd, 32'd0);
      @(negedge clk);
      check("mis_no_write", 32'(we_count), 32'(wc));
      check("mis_mem0", mem[0], 32'd0);

      // Contention from a fresh reset (pointer back at port 0).
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      p0_write = 0; p0_size = 2'b10; p0_unsigned = 0; p0_addr = 32'h8;
      p1_write = 0; p1_size = 2'b10; p1_unsigned = 0; p1_addr = 32'h4;
      p0_valid = 1'b1; p1_valid = 1'b1;
      n = 0;
      for (int i = 0; i < 20 && n < 4; i++) begin
         @(posedge clk); @(negedge clk);
         if (p0_done && p1_done) check("both_done", 32'd1, 32'd0);
         if (p0_done) begin seq[n] = 0; n++; end
         else if (p1_done) begin
            seq[n] = 1; n++;
            check("p1_rdata", p1_rdata, 32'h11AA3344);
            check("p1_err", 32'(p1_err), 32'd0);
         end
      end
      p0_valid = 1'b0; p1_valid = 1'b0;
      check("arb_count", 32'(n), 32'd4);
`ifdef ARB_RR_EN
      check("arb_g0", 32'(seq[0]), 32'd0);
      check("arb_g1", 32'(seq[1]), 32'd1);
      check("arb_g2", 32'(seq[2]), 32'd0);
      check("arb_g3", 32'(seq[3]), 32'd1);
`else
      check("arb_g0", 32'(seq[0]), 32'd0);
      check("arb_g1", 32'(seq[1]), 32'd0);
      check("arb_g2", 32'(seq[2]), 32'd0);
      check("arb_g3", 32'(seq[3]), 32'd0);
`endif
      @(negedge clk);

      // Reset during ACCESS of a byte store drops it.
      wc = we_count;
      m1 = mem[1];
      seen = 1'b0;
      p0_write = 1'b1; p0_size = 2'b00; p0_unsigned = 0; p0_addr = 32'h4; p0_wdata = 32'h77;
      p0_valid = 1'b1;
      @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      p0_valid = 1'b0;
      repeat (2) begin @(negedge clk); seen = seen | p0_done | p1_done; end
      reset = 1'b0;
      repeat (2) begin @(negedge clk); seen = seen | p0_done | p1_done; end
      check("rstmid_no_done", 32'(seen), 32'd0);
      check("rstmid_no_write", 32'(we_count), 32'(wc));
      check("rstmid_mem", mem[1], m1);
      p0_access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat, e, rd);
      check("rstmid_idle_lat", 32'(lat), 32'd1);
      check("rstmid_idle_rd", rd, 32'h11AA3344);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
